// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC select codes,
// fetch FSM states and the redirect priority encoder.
package fetch_pkg;

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    // Register jump outranks direct jump, which outranks a taken branch.
    function automatic logic [1:0] npc_select(input logic br_taken,
                                              input logic jmp,
                                              input logic jr);
        if (jr)            return NPC_JR;
        else if (jmp)      return NPC_J;
        else if (br_taken) return NPC_BR;
        else               return NPC_SEQ;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: single outstanding request, response
// qualified by imem_valid.
interface fetch_stage_if #(parameter int W = 32);

    logic          imem_req;
    logic [W-1:0]  imem_addr;
    logic          imem_valid;
    logic [31:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_stage_mux4.sv
// Four-way next-PC selector: sequential, branch, direct jump, register jump.
module mux4
    import fetch_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    output logic [W-1:0] out
);

    always_comb begin
        out = in0;
        case (sel)
            NPC_BR:  out = in1;
            NPC_J:   out = in2;
            NPC_JR:  out = in3;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem read in flight and
// fills the IF/ID register, honouring decode stall and EX redirects.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int           W        = 32,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          br_taken,
    input  logic          jmp,
    input  logic          jr,
    input  logic [W-1:0]  br_target,
    input  logic [W-1:0]  j_target,
    input  logic [W-1:0]  jr_target,
    fetch_stage_if.master imem,
    output logic [W-1:0]  pc,
    output logic          ifid_valid,
    output logic [31:0]   ifid_instr,
    output logic [W-1:0]  ifid_pc4
);

    fetch_state_e state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [W-1:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0]  hold_buf_q, hold_buf_d;
    logic         drop_q, drop_d;

    logic         redirect;
    logic [1:0]   npc_sel;
    logic [W-1:0] pc_plus4;
    logic [W-1:0] npc;

    assign redirect = br_taken | jmp | jr;
    assign npc_sel  = npc_select(br_taken, jmp, jr);
    assign pc_plus4 = pc_q + W'(4);

    mux4 #(.W(W)) u_npc_mux (
        .sel (npc_sel),
        .in0 (pc_plus4),
        .in1 (br_target),
        .in2 (j_target),
        .in3 (jr_target),
        .out (npc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        hold_buf_d   = hold_buf_q;
        drop_d       = drop_q;

        // Decode consumes the current IF/ID entry whenever it is not stalled.
        if (!stall) ifid_valid_d = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect) begin
                    ifid_valid_d = 1'b0;
                    pc_d         = npc;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    ifid_valid_d = 1'b0;
                    pc_d         = npc;
                    if (imem.imem_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem.imem_valid) begin
                    state_d = REQ;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else if (!stall) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = imem.imem_rdata;
                        ifid_pc4_d   = pc_plus4;
                        pc_d         = npc;
                    end else begin
                        hold_buf_d = imem.imem_rdata;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                // A redirect abandons the buffered word; leaving HOLD discards it.
                if (redirect) begin
                    ifid_valid_d = 1'b0;
                    pc_d         = npc;
                    state_d      = REQ;
                end else if (!stall) begin
                    ifid_valid_d = 1'b1;
                    ifid_instr_d = hold_buf_q;
                    ifid_pc4_d   = pc_plus4;
                    pc_d         = npc;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            hold_buf_q   <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            hold_buf_q   <= hold_buf_d;
            drop_q       <= drop_d;
        end
    end

    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign ifid_valid     = ifid_valid_q;
    assign ifid_instr     = ifid_instr_q;
    assign ifid_pc4       = ifid_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an imem responder with programmable latency, a
// transaction-level fetch model, directed scenarios and a randomized run.
module tb_fetch_stage;

   localparam int W = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, br_taken, jmp, jr;
   logic [31:0] br_target, j_target, jr_target;
   logic [31:0] pc, ifid_instr, ifid_pc4;
   logic        ifid_valid;
   logic [31:0] w_pc, w_instr, w_pc4;
   logic        w_valid;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: expected architectural view of the fetch stage
   logic [31:0] m_pc, m_instr, m_pc4, m_hbuf;
   bit          m_ifv, m_issue, m_wait, m_held, m_drop, m_fresh;

   // Memory responder state
   int          mem_cnt;
   logic [31:0] mem_addr;
   int          cur_lat;
   bit          w_req_prev;

   always #5 clk = ~clk;

   fetch_stage_if #(.W(W)) imem_bus ();
   fetch_stage_if #(.W(W)) w_bus ();

   fetch_stage #(.W(W), .RESET_PC(32'h0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .br_taken   (br_taken),
      .jmp        (jmp),
      .jr         (jr),
      .br_target  (br_target),
      .j_target   (j_target),
      .jr_target  (jr_target),
      .imem       (imem_bus.master),
      .pc         (pc),
      .ifid_valid (ifid_valid),
      .ifid_instr (ifid_instr),
      .ifid_pc4   (ifid_pc4)
   );

   // Second instance exercising PC wrap from the top of the address space
   fetch_stage #(.W(W), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (1'b0),
      .br_taken   (1'b0),
      .jmp        (1'b0),
      .jr         (1'b0),
      .br_target  (32'h0),
      .j_target   (32'h0),
      .jr_target  (32'h0),
      .imem       (w_bus.master),
      .pc         (w_pc),
      .ifid_valid (w_valid),
      .ifid_instr (w_instr),
      .ifid_pc4   (w_pc4)
   );

   // Memory contents are a fixed function of the address
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_hbuf = 32'h0;
      m_ifv = 0; m_issue = 0; m_wait = 0; m_held = 0; m_drop = 0; m_fresh = 1;
      mem_cnt = 0; mem_addr = 32'h0; w_req_prev = 0;
   endtask

   task automatic randTargets();
      br_target = $urandom() & 32'hFFFF_FFFC;
      j_target  = $urandom() & 32'hFFFF_FFFC;
      jr_target = $urandom() & 32'hFFFF_FFFC;
   endtask

   // One clock of stimulus: drive inputs, check request outputs, advance the
   // model, clock, then compare the registered outputs.
   task automatic applyStimulus(input bit st, input bit bt, input bit jp, input bit jrr, input bit spurious);
      logic [31:0] tgt, rd, addr_now;
      bit          redir, v, req_now, wreq_now;
      stall = st; br_taken = bt; jmp = jp; jr = jrr;
      v  = (mem_cnt == 1) || (spurious && mem_cnt == 0 && !m_wait);
      rd = (mem_cnt == 1) ? instr_of(mem_addr) : $urandom();
      imem_bus.imem_valid = v;
      imem_bus.imem_rdata = rd;
      w_bus.imem_valid    = w_req_prev;
      w_bus.imem_rdata    = 32'hCAFE_0001;
      #1;
      checkOutput("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, m_issue});
      if (m_issue) checkOutput("imem_addr", imem_bus.imem_addr, m_pc);
      req_now  = imem_bus.imem_req;
      addr_now = imem_bus.imem_addr;
      wreq_now = w_bus.imem_req;

      redir = bt | jp | jrr;
      tgt   = jrr ? jr_target : (jp ? j_target : br_target);
      if (!st) m_ifv = 0;
      if (m_fresh) begin
         m_fresh = 0; m_issue = 1;
      end else if (redir) begin
         m_ifv = 0; m_pc = tgt;
         if (m_wait && !v) m_drop = 1;
         else begin m_wait = 0; m_held = 0; m_issue = 1; m_drop = 0; end
      end else if (m_issue) begin
         m_issue = 0; m_wait = 1;
      end else if (m_wait && v) begin
         m_wait = 0; m_issue = 1;
         if (m_drop) m_drop = 0;
         else if (!st) begin m_ifv = 1; m_instr = rd; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; end
         else begin m_held = 1; m_hbuf = rd; m_issue = 0; end
      end else if (m_held && !st) begin
         m_held = 0; m_issue = 1;
         m_ifv = 1; m_instr = m_hbuf; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      end

      @(posedge clk); #1;
      if (req_now) begin mem_cnt = cur_lat; mem_addr = addr_now; end
      else if (mem_cnt > 0) mem_cnt--;
      w_req_prev = wreq_now;

      checkOutput("pc", pc, m_pc);
      checkOutput("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_ifv});
      checkOutput("ifid_instr", ifid_instr, m_instr);
      checkOutput("ifid_pc4", ifid_pc4, m_pc4);
   endtask

   task automatic stepUntilWait(input int budget);
      int n = 0;
      while (!m_wait && n < budget) begin
         applyStimulus(0, 0, 0, 0, 0);
         n++;
      end
      n_cmp++;
      assert (m_wait)
      else begin
         n_err++;
         $error("[TB] FAIL wait_timeout: observed=%0d expected=%0d", n, budget);
      end
   endtask

   initial begin
      rst_n = 1'b0; stall = 0; br_taken = 0; jmp = 0; jr = 0;
      br_target = 0; j_target = 0; jr_target = 0;
      imem_bus.imem_valid = 0; imem_bus.imem_rdata = 0;
      w_bus.imem_valid = 0; w_bus.imem_rdata = 0;
      cur_lat = 1;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
      checkOutput("rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
      checkOutput("rst_ifid_instr", ifid_instr, 32'h0);
      checkOutput("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
      rst_n = 1'b1;
      $display("[TB] reset released");

      // Sequential fetch with single-cycle memory, plus wrap instance
      repeat (3) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("wrap_ifid_valid", {31'b0, w_valid}, 32'h1);
      checkOutput("wrap_ifid_pc4", w_pc4, 32'h0);
      checkOutput("wrap_pc", w_pc, 32'h0);
      checkOutput("wrap_ifid_instr", w_instr, 32'hCAFE_0001);
      checkOutput("seq_first_pc4", ifid_pc4, 32'h4);
      repeat (3) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("seq_second_pc4", ifid_pc4, 32'h8);
      checkOutput("seq_second_instr", ifid_instr, instr_of(32'h4));

      // Stall while the response returns, then release
      repeat (5) applyStimulus(1, 0, 0, 0, 0);
      repeat (4) applyStimulus(0, 0, 0, 0, 0);

      // Register jump while a slow response is outstanding
      cur_lat = 3;
      applyStimulus(0, 0, 0, 0, 0);
      stepUntilWait(10);
      randTargets();
      jr_target = 32'h100;
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("redir_pc", pc, 32'h100);
      checkOutput("redir_flush", {31'b0, ifid_valid}, 32'h0);
      repeat (8) applyStimulus(0, 0, 0, 0, 0);

      // All redirect sources together under stall: register jump wins
      cur_lat = 1;
      stepUntilWait(10);
      randTargets();
      jr_target = 32'hFFFF_FFFC;
      applyStimulus(1, 1, 1, 1, 0);
      checkOutput("prio_pc", pc, 32'hFFFF_FFFC);
      checkOutput("prio_flush", {31'b0, ifid_valid}, 32'h0);
      repeat (4) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("wrap_redir_pc4", ifid_pc4, 32'h0);

      // Randomized traffic: redirects only while no request is being issued
      for (int i = 0; i < 800; i++) begin
         bit st, sp;
         int r;
         randTargets();
         cur_lat = $urandom_range(1, 3);
         st = ($urandom_range(0, 3) == 0);
         sp = ($urandom_range(0, 3) == 0);
         r  = 0;
         if (!m_issue && !m_fresh && $urandom_range(0, 7) == 0) r = $urandom_range(1, 7);
         applyStimulus(st, r[0], r[1], r[2], sp);
      end

      // Asynchronous reset asserted mid-WAIT
      cur_lat = 3;
      stepUntilWait(10);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_pc", pc, 32'h0);
      checkOutput("async_rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
      checkOutput("async_rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      imem_bus.imem_valid = 0;
      modelReset();
      cur_lat = 1;
      repeat (6) applyStimulus(0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
